// File: rtl/timer_bank_pkg.sv
// Shared definitions for the interval timer bank: register offsets,
// CTRL bit positions and the channel-to-status-bit mapping.
package timer_bank_pkg;

    localparam logic [3:0] REG_INDEX    = 4'h0;
    localparam logic [3:0] REG_RELOAD0  = 4'h1;
    localparam logic [3:0] REG_RELOAD1  = 4'h2;
    localparam logic [3:0] REG_RELOAD2  = 4'h3;
    localparam logic [3:0] REG_CTRL     = 4'h4;
    localparam logic [3:0] REG_LOAD     = 4'h5;
    localparam logic [3:0] REG_STATUS   = 4'h6;
    localparam logic [3:0] REG_PRESCALE = 4'h7;
    localparam logic [3:0] REG_VALUE0   = 4'h8;
    localparam logic [3:0] REG_VALUE1   = 4'h9;
    localparam logic [3:0] REG_VALUE2   = 4'hA;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_IRQEN   = 2;

    // Channel 0 sits in the MSB of the status byte, channel 7 in the LSB.
    function automatic logic [2:0] status_bit(input int ch);
        return 3'(7 - ch);
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counting interval timer: counter, control bits and sticky
// pending flag. Ticks come from the shared prescaler in the parent.
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] reload,
    input  logic             ctrl_wr,
    input  logic [2:0]       ctrl_data,
    input  logic             pend_clr,
    output logic [WIDTH-1:0] value,
    output logic             pending,
    output logic             enable,
    output logic             oneshot,
    output logic             irq_en
);

    logic run;
    logic fire;

    // A LOAD in the same cycle as a tick suppresses both the decrement and the fire.
    assign run  = tick && enable && !load;
    assign fire = run && (value == '0);

    // Counter: LOAD has priority, otherwise count down and reload on expiry in periodic mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= reload;
        end else if (run) begin
            if (value != '0) begin
                value <= value - WIDTH'(1);
            end else if (!oneshot) begin
                value <= reload;
            end
        end
    end

    // Control bits: a CPU write overrides the one-shot auto-disable in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable  <= 1'b0;
            oneshot <= 1'b0;
            irq_en  <= 1'b0;
        end else if (ctrl_wr) begin
            enable  <= ctrl_data[CTRL_EN];
            oneshot <= ctrl_data[CTRL_ONESHOT];
            irq_en  <= ctrl_data[CTRL_IRQEN];
        end else if (fire && oneshot) begin
            enable  <= 1'b0;
        end
    end

    // Sticky pending flag: a hardware set beats a simultaneous write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (fire) begin
            pending <= 1'b1;
        end else if (pend_clr) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/timer_bank.sv
// Bank of interval timers behind a byte-wide register window. Holds the
// register decode, reload registers, the shared prescaler and read mux.
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int NUM_TIMERS    = 8,
    parameter int WIDTH         = 20,
    parameter int PRESCALE_BITS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] addr,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       irq,
    output logic [7:0] irq_status
);

    localparam logic [3:0] NT = 4'(NUM_TIMERS);

    logic [2:0]               index_q;
    logic [PRESCALE_BITS-1:0] prescale_q;
    logic [PRESCALE_BITS-1:0] pcount_q;
    logic                     tick;
    logic                     idx_ok;
    logic [NUM_TIMERS-1:0]    ch_sel;

    logic [WIDTH-1:0]         reload_q [NUM_TIMERS];
    logic [WIDTH-1:0]         value_w  [NUM_TIMERS];
    logic [NUM_TIMERS-1:0]    pending_w;
    logic [NUM_TIMERS-1:0]    enable_w;
    logic [NUM_TIMERS-1:0]    oneshot_w;
    logic [NUM_TIMERS-1:0]    irq_en_w;

    logic [WIDTH-1:0]         cur_reload;
    logic [WIDTH-1:0]         cur_value;
    logic [2:0]               cur_ctrl;
    logic [23:0]              cur_reload_ext;
    logic [23:0]              cur_value_ext;
    logic [7:0]               rd_mux;

    // Replace one byte of a WIDTH-bit register; bits at or above WIDTH fall away.
    function automatic logic [WIDTH-1:0] merge_byte(input logic [WIDTH-1:0] cur,
                                                    input int k,
                                                    input logic [7:0] b);
        logic [23:0] ext;
        ext = 24'(cur);
        ext[8*k +: 8] = b;
        return ext[WIDTH-1:0];
    endfunction

    assign idx_ok = {1'b0, index_q} < NT;
    assign tick   = (pcount_q == prescale_q);
    assign irq    = |(pending_w & irq_en_w);

    // Channel select; an out-of-range INDEX selects nothing.
    always_comb begin
        ch_sel = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            ch_sel[i] = idx_ok && (index_q == 3'(i));
        end
    end

    // Index and prescaler reload registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            index_q    <= '0;
            prescale_q <= '0;
        end else if (wr_en) begin
            if (addr == REG_INDEX)    index_q    <= wr_data[2:0];
            if (addr == REG_PRESCALE) prescale_q <= wr_data[PRESCALE_BITS-1:0];
        end
    end

    // Free-running prescaler; wraps to zero on the cycle it issues a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcount_q <= '0;
        end else if (tick) begin
            pcount_q <= '0;
        end else begin
            pcount_q <= pcount_q + PRESCALE_BITS'(1);
        end
    end

    // Per-channel reload registers, written a byte at a time through INDEX.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_TIMERS; i++) reload_q[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (ch_sel[i]) begin
                    case (addr)
                        REG_RELOAD0: reload_q[i] <= merge_byte(reload_q[i], 0, wr_data);
                        REG_RELOAD1: reload_q[i] <= merge_byte(reload_q[i], 1, wr_data);
                        REG_RELOAD2: reload_q[i] <= merge_byte(reload_q[i], 2, wr_data);
                        default: ;
                    endcase
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
        timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .tick      (tick),
            .load      (wr_en && ch_sel[i] && (addr == REG_LOAD)),
            .reload    (reload_q[i]),
            .ctrl_wr   (wr_en && ch_sel[i] && (addr == REG_CTRL)),
            .ctrl_data (wr_data[2:0]),
            .pend_clr  (wr_en && (addr == REG_STATUS) && wr_data[status_bit(i)]),
            .value     (value_w[i]),
            .pending   (pending_w[i]),
            .enable    (enable_w[i]),
            .oneshot   (oneshot_w[i]),
            .irq_en    (irq_en_w[i])
        );
    end

    // Pending flags packed MSB-first by channel; bits of absent channels stay 0.
    always_comb begin
        irq_status = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            irq_status[status_bit(i)] = pending_w[i];
        end
    end

    // Fields of the currently indexed channel, all zero when INDEX is out of range.
    always_comb begin
        cur_reload = '0;
        cur_value  = '0;
        cur_ctrl   = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (ch_sel[i]) begin
                cur_reload = reload_q[i];
                cur_value  = value_w[i];
                cur_ctrl   = {irq_en_w[i], oneshot_w[i], enable_w[i]};
            end
        end
    end

    assign cur_reload_ext = 24'(cur_reload);
    assign cur_value_ext  = 24'(cur_value);

    // Read data select by offset; LOAD and unmapped offsets read 0.
    always_comb begin
        rd_mux = '0;
        case (addr)
            REG_INDEX:    rd_mux = {5'b0, index_q};
            REG_RELOAD0:  rd_mux = cur_reload_ext[7:0];
            REG_RELOAD1:  rd_mux = cur_reload_ext[15:8];
            REG_RELOAD2:  rd_mux = cur_reload_ext[23:16];
            REG_CTRL:     rd_mux = {5'b0, cur_ctrl};
            REG_STATUS:   rd_mux = irq_status;
            REG_PRESCALE: rd_mux = 8'(prescale_q);
            REG_VALUE0:   rd_mux = cur_value_ext[7:0];
            REG_VALUE1:   rd_mux = cur_value_ext[15:8];
            REG_VALUE2:   rd_mux = cur_value_ext[23:16];
            default:      rd_mux = '0;
        endcase
    end

    // Registered read port; holds its last value while rd_en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_mux;
        end
    end

endmodule
